// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head entry is always on dout.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_depth_check
        $error("sync_fifo DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees the slot before the push lands, so full+pop+push is accepted.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a small receive FIFO,
// with sticky framing and overrun flags cleared by clr_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 12_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_BIT - 1);

    if (CLKS_PER_BIT < 8) begin : g_baud_check
        $error("uart_rx: CLK_FREQ/BAUD must be at least 8");
    end

    logic          rx_meta;
    logic          rx_s;
    rx_state_t     state;
    rx_state_t     state_next;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          cnt_clr;
    logic          shift_en;
    logic          push;
    logic          frame_evt;
    logic          fifo_empty;
    logic          fifo_full;
    logic          drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        push       = 1'b0;
        frame_evt  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    cnt_clr    = 1'b1;
                end
            end
            START: begin
                if (baud_cnt == HALF_LAST) begin
                    cnt_clr    = 1'b1;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt == BIT_LAST) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_cnt == BIT_LAST) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_evt  = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= '0;
        end else if (cnt_clr) begin
            baud_cnt <= '0;
        end else if ((state == START) || (state == DATA) || (state == STOP)) begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            if (state == START) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (shift_en) begin
                shift <= {rx_s, shift[7:1]};
            end
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (rd_en),
        .din   (shift),
        .dout  (data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign drop = push && fifo_full && !rd_en;

    // Error events take priority over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_evt) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

    assign data_valid = !fifo_empty;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (104 clocks per bit).
module tb_uart_rx;

    localparam int unsigned BIT = 104;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ   (12_000_000),
        .BAUD       (115_200),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rd_en      (rd_en),
        .clr_err    (clr_err),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Caller must be 1 time unit after a rising edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int unsigned stop_len);
        logic [8:0] bits;
        bits = {b, 1'b0};
        for (int i = 0; i < 9; i++) begin
            rx = bits[i];
            repeat (BIT) @(posedge clk);
            #1;
        end
        rx = stop_val;
        repeat (stop_len) @(posedge clk);
        #1;
        rx = 1'b1;
    endtask

    task automatic pop_byte();
        @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset   = 1'b1;
        rx      = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_ferr",  32'(frame_err),  32'd0);
        check("rst_ovr",   32'(overrun),    32'd0);
        check("rst_busy",  32'(busy),       32'd0);

        // Single byte with exact push latency
        @(posedge clk);
        #1;
        fork
            send_frame(8'hA5, 1'b1, BIT);
            begin
                repeat (990) @(posedge clk);
                @(negedge clk);
                check("a5_before", 32'(data_valid), 32'd0);
                @(posedge clk);
                @(negedge clk);
                check("a5_valid", 32'(data_valid), 32'd1);
                check("a5_data",  32'(data),       32'hA5);
            end
        join
        check("a5_ferr", 32'(frame_err), 32'd0);
        pop_byte();
        check("a5_popped", 32'(data_valid), 32'd0);

        // Glitch rejection
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (20) @(posedge clk);
        #1 rx = 1'b1;
        @(negedge clk);
        check("gl_busy_mid", 32'(busy), 32'd1);
        repeat (34) @(posedge clk);
        @(negedge clk);
        check("gl_busy_54", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("gl_busy_55", 32'(busy), 32'd0);
        check("gl_valid",   32'(data_valid), 32'd0);
        check("gl_ferr",    32'(frame_err),  32'd0);
        check("gl_ovr",     32'(overrun),    32'd0);

        // Framing error with long low stop bit
        @(posedge clk);
        #1;
        fork
            send_frame(8'h3C, 1'b0, 300);
            begin
                repeat (1100) @(posedge clk);
                @(negedge clk);
                check("fe_flag",  32'(frame_err),  32'd1);
                check("fe_break", 32'(busy),       32'd1);
                check("fe_empty", 32'(data_valid), 32'd0);
            end
        join
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("fe_idle", 32'(busy), 32'd0);
        pulse_clr();
        check("fe_clr", 32'(frame_err), 32'd0);

        // Overrun: five frames into a four-entry FIFO
        @(posedge clk);
        #1;
        for (int b = 1; b <= 5; b++) begin
            send_frame(8'(b), 1'b1, BIT);
        end
        @(negedge clk);
        check("ov_flag", 32'(overrun), 32'd1);
        for (int b = 1; b <= 4; b++) begin
            check("ov_head", 32'(data), 32'(b));
            pop_byte();
        end
        check("ov_drained", 32'(data_valid), 32'd0);
        pulse_clr();
        check("ov_clr", 32'(overrun), 32'd0);

        // Full FIFO with pop in the push cycle
        @(posedge clk);
        #1;
        for (int b = 8'h11; b <= 8'h14; b++) begin
            send_frame(8'(b), 1'b1, BIT);
        end
        fork
            send_frame(8'h77, 1'b1, BIT);
            begin
                repeat (990) @(posedge clk);
                #1 rd_en = 1'b1;
                @(posedge clk);
                #1 rd_en = 1'b0;
                @(negedge clk);
                check("fp_ovr",  32'(overrun), 32'd0);
                check("fp_head", 32'(data),    32'h12);
            end
        join
        pop_byte();
        check("fp_h13", 32'(data), 32'h13);
        pop_byte();
        check("fp_h14", 32'(data), 32'h14);
        pop_byte();
        check("fp_h77",  32'(data),       32'h77);
        check("fp_left", 32'(data_valid), 32'd1);

        // Reset during bit 4 of 0xFF, then a clean frame
        @(posedge clk);
        #1;
        fork
            send_frame(8'hFF, 1'b1, BIT);
            begin
                repeat (BIT * 5 + 50) @(posedge clk);
                #1 reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
                @(negedge clk);
                check("mr_busy",  32'(busy),       32'd0);
                check("mr_valid", 32'(data_valid), 32'd0);
                check("mr_ferr",  32'(frame_err),  32'd0);
                check("mr_ovr",   32'(overrun),    32'd0);
            end
        join
        @(negedge clk);
        check("mr_nopush", 32'(data_valid), 32'd0);
        @(posedge clk);
        #1;
        send_frame(8'h5A, 1'b1, BIT);
        @(negedge clk);
        check("mr_valid2", 32'(data_valid), 32'd1);
        check("mr_data",   32'(data),       32'h5A);
        check("mr_ferr2",  32'(frame_err),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
